// File: rtl/line_fetch_ctrl.sv
// Scanline fetch controller: reads LINE_WORDS consecutive words of one scanline
// from pixel memory (one outstanding request at a time) and streams them into
// the scanline FIFO, honouring FIFO back-pressure without dropping or
// duplicating words.
module line_fetch_ctrl #(
    parameter int unsigned LINE_WORDS  = 700,
    parameter int unsigned LINE_STRIDE = 1024,
    parameter int unsigned ADDR_W      = 20
) (
    input  logic              clk100,
    input  logic              rst,
    input  logic              lineStart,
    input  logic [9:0]        lineNum,
    output logic              memReq,
    output logic [ADDR_W-1:0] memAddr,
    input  logic              memAck,
    input  logic [15:0]       memData,
    output logic [15:0]       fifoData,
    output logic              fifoWrreq,
    input  logic              fifoFull,
    output logic              busy,
    output logic              lineDone,
    output logic              overrun
);

    localparam int unsigned IDX_W = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(LINE_WORDS - 1);
    localparam logic [ADDR_W-1:0] STRIDE   = ADDR_W'(LINE_STRIDE);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WR
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] base_q,    base_d;
    logic [IDX_W-1:0]  idx_q,     idx_d;
    logic [15:0]       hold_q,    hold_d;
    logic              overrun_q, overrun_d;

    // Address and write data come straight from registers, so memAddr is
    // stable for the whole request and fifoData for the whole write wait.
    assign memAddr  = base_q + ADDR_W'(idx_q);
    assign fifoData = hold_q;
    assign overrun  = overrun_q;

    // Next-state and output decode for the IDLE/REQ/WR fetch sequence.
    always_comb begin
        state_d   = state_q;
        base_d    = base_q;
        idx_d     = idx_q;
        hold_d    = hold_q;
        overrun_d = 1'b0;
        memReq    = 1'b0;
        fifoWrreq = 1'b0;
        lineDone  = 1'b0;
        busy      = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (lineStart) begin
                    // Product taken modulo 2^ADDR_W; both operands are
                    // already ADDR_W wide so truncation is implicit.
                    base_d  = ADDR_W'(lineNum) * STRIDE;
                    idx_d   = '0;
                    state_d = S_REQ;
                end
            end

            S_REQ: begin
                busy      = 1'b1;
                memReq    = 1'b1;
                overrun_d = lineStart;
                if (memAck) begin
                    hold_d  = memData;
                    state_d = S_WR;
                end
            end

            S_WR: begin
                busy      = 1'b1;
                overrun_d = lineStart;
                if (!fifoFull) begin
                    fifoWrreq = 1'b1;
                    if (idx_q == LAST_IDX) begin
                        lineDone = 1'b1;
                        state_d  = S_IDLE;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        state_d = S_REQ;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; synchronous reset aborts any line in flight.
    always_ff @(posedge clk100) begin
        if (rst) begin
            state_q   <= S_IDLE;
            base_q    <= '0;
            idx_q     <= '0;
            hold_q    <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            base_q    <= base_d;
            idx_q     <= idx_d;
            hold_q    <= hold_d;
            overrun_q <= overrun_d;
        end
    end

endmodule

// File: tb/tb_line_fetch_ctrl.sv
// Self-checking bench for line_fetch_ctrl: a memory/FIFO responder, a
// scoreboard of expected FIFO words, a table of line-fetch scenarios and
// hand-written reset sequences.
module tb_line_fetch_ctrl;

    localparam int LW = 700;

    logic        clk100;
    logic        rst;
    logic        lineStart;
    logic [9:0]  lineNum;
    logic        memReq;
    logic [19:0] memAddr;
    logic        memAck;
    logic [15:0] memData;
    logic [15:0] fifoData;
    logic        fifoWrreq;
    logic        fifoFull;
    logic        busy;
    logic        lineDone;
    logic        overrun;

    line_fetch_ctrl #(
        .LINE_WORDS (700),
        .LINE_STRIDE(1024),
        .ADDR_W     (20)
    ) dut (
        .clk100   (clk100),
        .rst      (rst),
        .lineStart(lineStart),
        .lineNum  (lineNum),
        .memReq   (memReq),
        .memAddr  (memAddr),
        .memAck   (memAck),
        .memData  (memData),
        .fifoData (fifoData),
        .fifoWrreq(fifoWrreq),
        .fifoFull (fifoFull),
        .busy     (busy),
        .lineDone (lineDone),
        .overrun  (overrun)
    );

    typedef struct {
        int line_num;
        int delay;
        int stall_idx;
        int stall_len;
        int ovr_idx;
        bit ovr_last;
        int exp_first;
        int exp_last;
    } vec_t;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          ack_delay   = 0;
    int          wait_cnt    = 0;
    int          stall_idx   = -1;
    int          stall_left  = 0;
    int          stall_seen  = 0;
    int          line_writes = 0;
    int          done_cnt    = 0;
    int          first_cyc   = 0;
    int          last_cyc    = 0;
    bit          expect_active = 1'b0;
    bit          ack_idle      = 1'b0;
    logic [19:0] exp_base      = '0;
    logic [19:0] last_ack_addr = '0;
    logic [15:0] sb_q[$];

    function automatic logic [15:0] fdata(input logic [19:0] a);
        return a[15:0] ^ {a[19:16], a[19:16], 8'h3C};
    endfunction

    task automatic check(input string nm, input int unsigned act, input int unsigned exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk100);
        #2;
    endtask

    initial begin
        clk100 = 1'b0;
        forever #5 clk100 = ~clk100;
    end

    initial begin
        forever begin
            @(posedge clk100);
            cyc++;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Memory and FIFO responder, driven just after each rising edge.
    initial begin
        memAck   = 1'b0;
        memData  = '0;
        fifoFull = 1'b0;
        forever begin
            @(posedge clk100);
            #1;
            memAck   = 1'b0;
            fifoFull = 1'b0;
            if (memReq) begin
                if (wait_cnt >= ack_delay) begin
                    memAck   = 1'b1;
                    memData  = fdata(memAddr);
                    wait_cnt = 0;
                end else begin
                    wait_cnt++;
                end
            end else begin
                wait_cnt = 0;
                memAck   = ack_idle;
                memData  = 16'hDEAD;
                if (busy && line_writes == stall_idx && stall_left > 0) begin
                    fifoFull = 1'b1;
                    stall_left--;
                end
            end
        end
    end

    // Scoreboard / protocol checker, sampling on the falling edge.
    initial begin
        logic [19:0] a_exp;
        logic [15:0] d_exp;
        forever begin
            @(negedge clk100);
            if (!rst) begin
                if (memReq) begin
                    check("req_while_active", 32'(expect_active), 1);
                    a_exp = 20'(32'(exp_base) + 32'(line_writes));
                    check("memAddr", 32'(memAddr), 32'(a_exp));
                    if (memAck) last_ack_addr = memAddr;
                end
                if (fifoFull) begin
                    check("wrreq_while_full", 32'(fifoWrreq), 0);
                    if (busy && !memReq) stall_seen++;
                end
                if (fifoWrreq) begin
                    if (sb_q.size() == 0) begin
                        check("unexpected_write", 1, 0);
                    end else begin
                        d_exp = sb_q.pop_front();
                        check("fifoData", 32'(fifoData), 32'(d_exp));
                    end
                    check("lineDone_on_last", 32'(lineDone), 32'(line_writes == LW - 1));
                    if (line_writes == 0) first_cyc = cyc;
                    last_cyc = cyc;
                    line_writes++;
                    if (line_writes == LW) expect_active = 1'b0;
                end else begin
                    check("lineDone_without_write", 32'(lineDone), 0);
                end
                if (lineDone) done_cnt++;
            end
        end
    end

    task automatic launch(input int ln, input int first, input int delay,
                          input int s_idx, input int s_len);
        logic [19:0] a;
        ack_delay   = delay;
        stall_idx   = s_idx;
        stall_left  = s_len;
        stall_seen  = 0;
        exp_base    = 20'(first);
        line_writes = 0;
        done_cnt    = 0;
        for (int i = 0; i < LW; i++) begin
            a = 20'(first + i);
            sb_q.push_back(fdata(a));
        end
        expect_active = 1'b1;
        lineStart = 1'b1;
        lineNum   = 10'(ln);
        tick();
        lineStart = 1'b0;
        check("start_latency_memReq", 32'(memReq), 1);
        check("start_addr", 32'(memAddr), 32'(first));
        check("start_busy", 32'(busy), 1);
    endtask

    task automatic run_line(input vec_t v);
        int budget;
        int limit;
        int phase;
        bit inj_a;
        bit inj_b;
        launch(v.line_num, v.exp_first, v.delay, v.stall_idx, v.stall_len);
        limit  = LW * (v.delay + 2) + v.stall_len + 200;
        budget = 0;
        phase  = 0;
        inj_a  = 1'b0;
        inj_b  = 1'b0;
        while ((line_writes < LW || phase != 0) && budget < limit) begin
            tick();
            budget++;
            if (phase == 1) begin
                lineStart = 1'b0;
                check("overrun_pulse", 32'(overrun), 1);
                phase = 2;
            end else if (phase == 2) begin
                check("overrun_clear", 32'(overrun), 0);
                phase = 0;
            end else if (v.ovr_idx >= 0 && !inj_a && line_writes == v.ovr_idx && memReq) begin
                lineStart = 1'b1;
                lineNum   = 10'd7;
                inj_a     = 1'b1;
                phase     = 1;
            end else if (v.ovr_last && !inj_b && line_writes == LW - 1 && busy && !memReq && !fifoFull) begin
                lineStart = 1'b1;
                lineNum   = 10'd8;
                inj_b     = 1'b1;
                phase     = 1;
            end
        end
        lineStart = 1'b0;
        check("line_within_budget", 32'(budget < limit), 1);
        repeat (3) tick();
        check("line_writes", 32'(line_writes), LW);
        check("line_done_count", 32'(done_cnt), 1);
        check("busy_after_line", 32'(busy), 0);
        check("memReq_after_line", 32'(memReq), 0);
        check("scoreboard_empty", 32'(sb_q.size()), 0);
        check("last_addr", 32'(last_ack_addr), 32'(v.exp_last));
        check("write_span", 32'(last_cyc - first_cyc), 32'((LW - 1) * (v.delay + 2) + v.stall_len));
        check("stall_cycles", 32'(stall_seen), 32'(v.stall_len));
        if (v.ovr_idx >= 0) check("overrun_mid_injected", 32'(inj_a), 1);
        if (v.ovr_last)     check("overrun_last_injected", 32'(inj_b), 1);
    endtask

    initial begin
        vec_t vecs[5];
        vec_t v0;
        int   budget;

        vecs[0] = '{3,    0, -1,  0, -1, 1'b0, 3072,    3771};
        vecs[1] = '{12,   5, -1,  0, -1, 1'b0, 12288,   12987};
        vecs[2] = '{20,   0, 100, 20, -1, 1'b0, 20480,  21179};
        vecs[3] = '{1023, 1, -1,  0, -1, 1'b0, 1047552, 1048251};
        vecs[4] = '{5,    0, -1,  0, 50, 1'b1, 5120,    5819};
        v0      = '{0,    0, -1,  0, -1, 1'b0, 0,       699};

        rst       = 1'b1;
        lineStart = 1'b0;
        lineNum   = '0;
        repeat (3) tick();
        check("rst_memReq", 32'(memReq), 0);
        check("rst_fifoWrreq", 32'(fifoWrreq), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_lineDone", 32'(lineDone), 0);
        check("rst_overrun", 32'(overrun), 0);
        check("rst_fifoData", 32'(fifoData), 0);

        // memAck while idle must not start anything or load data.
        rst      = 1'b0;
        ack_idle = 1'b1;
        repeat (3) begin
            tick();
            check("idle_ack_busy", 32'(busy), 0);
            check("idle_ack_fifoData", 32'(fifoData), 0);
        end
        ack_idle = 1'b0;
        tick();

        foreach (vecs[k]) begin
            run_line(vecs[k]);
        end

        // Reset in the middle of a line, together with a fresh lineStart.
        launch(9, 9216, 0, -1, 0);
        budget = 0;
        while (!(line_writes == 200 && memReq) && budget < 3000) begin
            tick();
            budget++;
        end
        check("rst_mid_reached_200", 32'(line_writes), 200);
        rst       = 1'b1;
        lineStart = 1'b1;
        lineNum   = 10'd4;
        tick();
        rst           = 1'b0;
        lineStart     = 1'b0;
        expect_active = 1'b0;
        sb_q.delete();
        check("rst_mid_memReq", 32'(memReq), 0);
        check("rst_mid_fifoWrreq", 32'(fifoWrreq), 0);
        check("rst_mid_busy", 32'(busy), 0);
        check("rst_mid_overrun", 32'(overrun), 0);
        check("rst_mid_fifoData", 32'(fifoData), 0);
        repeat (6) begin
            tick();
            check("rst_mid_stays_idle", 32'(busy), 0);
        end
        check("rst_mid_no_lineDone", 32'(done_cnt), 0);

        run_line(v0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
